affine_stage_controller: RTL and testbench

- Schedule/address generator for one compute stage of the pointwise pipeline.
- Walks a 3-deep perfectly nested loop on a fixed affine schedule. Per iteration it drives one-cycle `valid` plus the three 16-bit loop-variable values.
- Outputs connect directly to a unified buffer's `*_wen`/`*_ren` and `*_ctrl_vars[2:0]` ports, upstream of that buffer.
- One instance per port: e.g. one for the input-wrapper write, one for the mult read/write, one for the output read.

---
 rtl/affine_ctrl_pkg.sv | 19 +
 rtl/affine_loop_counter.sv | 32 +++
 rtl/affine_stage_controller.sv | 102 ++++++++++
 tb/tb_affine_stage_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/affine_ctrl_pkg.sv
// Shared types for the affine stage controller: loop-variable width, wait-counter
// width and the schedule FSM states.
package affine_ctrl_pkg;

   localparam int CTRL_W   = 16;
   localparam int NUM_DIMS = 3;
   // One extra bit so II+ROW_GAP-1 (up to 131069) fits in the countdown.
   localparam int WAIT_W   = CTRL_W + 1;

   typedef logic [CTRL_W-1:0] ctrl_t;
   typedef logic [WAIT_W-1:0] wait_t;

   typedef enum logic [1:0] {
      WAIT_START,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/affine_loop_counter.sv
// One loop dimension: counts 0..extent-1 on inc and wraps; clr restarts it from 0
// in the same cycle so a restart edge can also issue and advance.
module affine_loop_counter
   import affine_ctrl_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clr,
   input  logic  inc,
   input  ctrl_t extent,
   output ctrl_t value,
   output logic  at_max
);

   ctrl_t base;

   assign base   = clr ? '0 : value;
   assign at_max = (base == (extent - ctrl_t'(1)));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value <= '0;
      end else if (inc) begin
         value <= at_max ? '0 : base + ctrl_t'(1);
      end else begin
         value <= base;
      end
   end

endmodule

// File: rtl/affine_stage_controller.sv
// Issues one valid strobe per iteration of a 3-deep nested loop on a fixed affine
// schedule (START offset, II spacing, ROW_GAP idle cycles after each dim-2 wrap).
module affine_stage_controller
   import affine_ctrl_pkg::*;
#(
   parameter int unsigned E0      = 1,
   parameter int unsigned E1      = 64,
   parameter int unsigned E2      = 64,
   parameter int unsigned START   = 0,
   parameter int unsigned II      = 1,
   parameter int unsigned ROW_GAP = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   output logic                       valid,
   output ctrl_t [NUM_DIMS-1:0]       ctrl_vars,
   output logic                       done
);

   if (E0 < 1 || E0 > 65535 || E1 < 1 || E1 > 65535 || E2 < 1 || E2 > 65535) begin : g_bad_extent
      $error("affine_stage_controller: extents must be in 1..65535");
   end
   if (II < 1 || II > 65535 || START > 65535 || ROW_GAP > 65535) begin : g_bad_timing
      $error("affine_stage_controller: II must be 1..65535, START/ROW_GAP 0..65535");
   end

   localparam ctrl_t [NUM_DIMS-1:0] EXTENTS = {ctrl_t'(E2), ctrl_t'(E1), ctrl_t'(E0)};
   localparam wait_t START_W  = wait_t'(START);
   localparam wait_t GAP_STEP = wait_t'(II - 1);
   localparam wait_t GAP_WRAP = wait_t'(II + ROW_GAP - 1);

   state_t                 state, state_nxt, eff_state;
   wait_t                  wait_cnt, wait_nxt, eff_wait;
   ctrl_t [NUM_DIMS-1:0]   cnt, eff_cnt, ctrl_nxt;
   logic  [NUM_DIMS-1:0]   at_max, inc;
   logic                   issue, last, advance, valid_nxt, done_nxt;

   // A flush edge behaves exactly like the first edge after reset release,
   // so START=0 issues (0,0,0) on that same edge.
   assign eff_state = flush ? WAIT_START : state;
   assign eff_wait  = flush ? START_W : wait_cnt;
   assign eff_cnt   = flush ? '0 : cnt;
   assign issue     = (eff_state != DONE) && (eff_wait == '0);
   assign last      = &at_max;
   assign advance   = issue && !last;

   assign inc[2] = advance;
   assign inc[1] = advance && at_max[2];
   assign inc[0] = advance && at_max[2] && at_max[1];

   for (genvar d = 0; d < NUM_DIMS; d++) begin : g_dim
      affine_loop_counter u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (flush),
         .inc    (inc[d]),
         .extent (EXTENTS[d]),
         .value  (cnt[d]),
         .at_max (at_max[d])
      );
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = eff_state;
      wait_nxt  = eff_wait;
      valid_nxt = 1'b0;
      done_nxt  = (eff_state == DONE);
      ctrl_nxt  = flush ? '0 : ctrl_vars;
      if (issue) begin
         valid_nxt = 1'b1;
         ctrl_nxt  = eff_cnt;
         if (last) begin
            state_nxt = DONE;
         end else begin
            state_nxt = RUN;
            wait_nxt  = at_max[2] ? GAP_WRAP : GAP_STEP;
         end
      end else if (eff_state != DONE) begin
         wait_nxt = eff_wait - wait_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= WAIT_START;
         wait_cnt  <= START_W;
         valid     <= 1'b0;
         ctrl_vars <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_nxt;
         valid     <= valid_nxt;
         ctrl_vars <= ctrl_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_affine_stage_controller.sv
// Directed bench for affine_stage_controller: four configurations side by side,
// table-driven cycle checks plus hand-written flush/reset/full-sweep sequences.
module tb_affine_stage_controller;
   import affine_ctrl_pkg::*;

   localparam int DEF    = 0;   // (1,64,64) START=0 II=1 GAP=0
   localparam int SPARSE = 1;   // (1,2,3)   START=5 II=2 GAP=3
   localparam int ROWGAP = 2;   // (2,1,2)   START=0 II=1 GAP=1
   localparam int SINGLE = 3;   // (1,1,1)   START=3 II=1 GAP=0

   typedef struct {
      int   tid;
      int   cyc;
      logic v;
      int   c0, c1, c2;
      logic d;
   } vec_t;

   logic                  clk = 1'b0;
   logic                  rst_n_w [4];
   logic                  flush_w [4];
   logic                  valid_w [4];
   ctrl_t [NUM_DIMS-1:0]  vars_w  [4];
   logic                  done_w  [4];

   int   total   = 0;
   int   bad     = 0;
   int   cur_cyc = 0;
   vec_t tab[$];

   always #5 clk = ~clk;

   affine_stage_controller #(.E0(1), .E1(64), .E2(64), .START(0), .II(1), .ROW_GAP(0)) u_def (
      .clk(clk), .rst_n(rst_n_w[DEF]), .flush(flush_w[DEF]),
      .valid(valid_w[DEF]), .ctrl_vars(vars_w[DEF]), .done(done_w[DEF]));

   affine_stage_controller #(.E0(1), .E1(2), .E2(3), .START(5), .II(2), .ROW_GAP(3)) u_sparse (
      .clk(clk), .rst_n(rst_n_w[SPARSE]), .flush(flush_w[SPARSE]),
      .valid(valid_w[SPARSE]), .ctrl_vars(vars_w[SPARSE]), .done(done_w[SPARSE]));

   affine_stage_controller #(.E0(2), .E1(1), .E2(2), .START(0), .II(1), .ROW_GAP(1)) u_rowgap (
      .clk(clk), .rst_n(rst_n_w[ROWGAP]), .flush(flush_w[ROWGAP]),
      .valid(valid_w[ROWGAP]), .ctrl_vars(vars_w[ROWGAP]), .done(done_w[ROWGAP]));

   affine_stage_controller #(.E0(1), .E1(1), .E2(1), .START(3), .II(1), .ROW_GAP(0)) u_single (
      .clk(clk), .rst_n(rst_n_w[SINGLE]), .flush(flush_w[SINGLE]),
      .valid(valid_w[SINGLE]), .ctrl_vars(vars_w[SINGLE]), .done(done_w[SINGLE]));

   function automatic logic [47:0] tup(input int a, input int b, input int c);
      return {16'(a), 16'(b), 16'(c)};
   endfunction

   function automatic logic [47:0] act_tup(input int id);
      return {vars_w[id][0], vars_w[id][1], vars_w[id][2]};
   endfunction

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cur_cyc++;
   endtask

   // Holds reset for one edge, checks the reset state, then releases; returns in cycle 0.
   task automatic do_reset(input int id);
      rst_n_w[id] = 1'b0;
      flush_w[id] = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("rst%0d_valid", id), 48'(valid_w[id]), 48'd0);
      check($sformatf("rst%0d_vars", id), act_tup(id), 48'd0);
      check($sformatf("rst%0d_done", id), 48'(done_w[id]), 48'd0);
      rst_n_w[id] = 1'b1;
      @(posedge clk);
      #1;
      cur_cyc = 0;
   endtask

   // Default config, entered in cycle 0: 4096 back-to-back issues into a 64x64 buffer.
   task automatic run_default_seq(input string tag);
      bit seen [4096];
      int seq_err   = 0;
      int dup       = 0;
      int unwritten = 0;
      int addr;
      for (int k = 0; k < 4096; k++) begin
         if (valid_w[DEF] !== 1'b1 || act_tup(DEF) !== tup(0, k / 64, k % 64) || done_w[DEF] !== 1'b0)
            seq_err++;
         if (valid_w[DEF] === 1'b1) begin
            addr = int'(vars_w[DEF][1]) * 64 + int'(vars_w[DEF][2]);
            if (addr < 0 || addr > 4095 || vars_w[DEF][0] !== 16'd0) seq_err++;
            else begin
               if (seen[addr]) dup++;
               seen[addr] = 1'b1;
            end
         end
         step();
      end
      for (int a = 0; a < 4096; a++) if (!seen[a]) unwritten++;
      check({tag, "_seq_errors"}, 48'(seq_err), 48'd0);
      check({tag, "_dup_writes"}, 48'(dup), 48'd0);
      check({tag, "_unwritten"}, 48'(unwritten), 48'd0);
      check({tag, "_end_valid"}, 48'(valid_w[DEF]), 48'd0);
      check({tag, "_end_done"}, 48'(done_w[DEF]), 48'd1);
      check({tag, "_end_hold"}, act_tup(DEF), tup(0, 63, 63));
      repeat (3) step();
      check({tag, "_done_held"}, 48'(done_w[DEF]), 48'd1);
   endtask

   task automatic add(input int tid, input int cyc, input logic v,
                      input int c0, input int c1, input int c2, input logic d);
      vec_t r;
      r.tid = tid; r.cyc = cyc; r.v = v; r.c0 = c0; r.c1 = c1; r.c2 = c2; r.d = d;
      tab.push_back(r);
   endtask

   initial begin
      int err;
      for (int i = 0; i < 4; i++) begin
         rst_n_w[i] = 1'b0;
         flush_w[i] = 1'b0;
      end

      // Sparse schedule: issues at 5,7,9 then 14,16,18; done from 19.
      add(SPARSE,  0, 0, 0,0,0, 0); add(SPARSE,  2, 0, 0,0,0, 0); add(SPARSE,  4, 0, 0,0,0, 0);
      add(SPARSE,  5, 1, 0,0,0, 0); add(SPARSE,  6, 0, 0,0,0, 0); add(SPARSE,  7, 1, 0,0,1, 0);
      add(SPARSE,  8, 0, 0,0,1, 0); add(SPARSE,  9, 1, 0,0,2, 0); add(SPARSE, 10, 0, 0,0,2, 0);
      add(SPARSE, 11, 0, 0,0,2, 0); add(SPARSE, 12, 0, 0,0,2, 0); add(SPARSE, 13, 0, 0,0,2, 0);
      add(SPARSE, 14, 1, 0,1,0, 0); add(SPARSE, 15, 0, 0,1,0, 0); add(SPARSE, 16, 1, 0,1,1, 0);
      add(SPARSE, 17, 0, 0,1,1, 0); add(SPARSE, 18, 1, 0,1,2, 0); add(SPARSE, 19, 0, 0,1,2, 1);
      add(SPARSE, 20, 0, 0,1,2, 1); add(SPARSE, 30, 0, 0,1,2, 1);
      // Outer-dim wrap with E1=1 and a one-cycle row gap.
      add(ROWGAP,  0, 1, 0,0,0, 0); add(ROWGAP,  1, 1, 0,0,1, 0); add(ROWGAP,  2, 0, 0,0,1, 0);
      add(ROWGAP,  3, 1, 1,0,0, 0); add(ROWGAP,  4, 1, 1,0,1, 0); add(ROWGAP,  5, 0, 1,0,1, 1);
      add(ROWGAP,  6, 0, 1,0,1, 1);

      foreach (tab[i]) begin
         if (i == 0 || tab[i].tid != tab[i-1].tid) do_reset(tab[i].tid);
         while (cur_cyc < tab[i].cyc) step();
         check($sformatf("t%0d_c%0d_valid", tab[i].tid, tab[i].cyc), 48'(valid_w[tab[i].tid]), 48'(tab[i].v));
         check($sformatf("t%0d_c%0d_vars", tab[i].tid, tab[i].cyc), act_tup(tab[i].tid),
               tup(tab[i].c0, tab[i].c1, tab[i].c2));
         check($sformatf("t%0d_c%0d_done", tab[i].tid, tab[i].cyc), 48'(done_w[tab[i].tid]), 48'(tab[i].d));
      end

      // Full default sweep from reset.
      do_reset(DEF);
      run_default_seq("def");

      // Flush at cycle 100 of the default config restarts with (0,0,0) immediately.
      do_reset(DEF);
      while (cur_cyc < 100) step();
      check("flush_pre_vars", act_tup(DEF), tup(0, 1, 36));
      check("flush_pre_valid", 48'(valid_w[DEF]), 48'd1);
      flush_w[DEF] = 1'b1;
      step();
      flush_w[DEF] = 1'b0;
      check("flush_c0_valid", 48'(valid_w[DEF]), 48'd1);
      check("flush_c0_vars", act_tup(DEF), tup(0, 0, 0));
      run_default_seq("flush");

      // Reset wins over flush: with START=0 a flush alone would issue, reset must not.
      do_reset(DEF);
      while (cur_cyc < 10) step();
      rst_n_w[DEF] = 1'b0;
      flush_w[DEF] = 1'b1;
      step();
      check("rstflush_def_valid", 48'(valid_w[DEF]), 48'd0);
      check("rstflush_def_vars", act_tup(DEF), 48'd0);
      rst_n_w[DEF] = 1'b1;
      flush_w[DEF] = 1'b0;
      step();
      check("rstflush_def_restart", 48'(valid_w[DEF]), 48'd1);

      // Reset+flush at cycle 37 of the sparse config (already done).
      do_reset(SPARSE);
      while (cur_cyc < 37) step();
      check("sparse_c37_done", 48'(done_w[SPARSE]), 48'd1);
      rst_n_w[SPARSE] = 1'b0;
      flush_w[SPARSE] = 1'b1;
      step();
      check("rst37_valid", 48'(valid_w[SPARSE]), 48'd0);
      check("rst37_vars", act_tup(SPARSE), 48'd0);
      check("rst37_done", 48'(done_w[SPARSE]), 48'd0);
      rst_n_w[SPARSE] = 1'b1;
      flush_w[SPARSE] = 1'b0;
      step();
      cur_cyc = 0;
      err = 0;
      for (int k = 0; k < 5; k++) begin
         if (valid_w[SPARSE] !== 1'b0) err++;
         step();
      end
      check("rst37_early_valid", 48'(err), 48'd0);
      check("rst37_first_valid", 48'(valid_w[SPARSE]), 48'd1);
      check("rst37_first_vars", act_tup(SPARSE), tup(0, 0, 0));

      // Flush out of DONE in the sparse config: restart with START=5 offset.
      while (cur_cyc < 25) step();
      flush_w[SPARSE] = 1'b1;
      step();
      flush_w[SPARSE] = 1'b0;
      check("flushdone_c0_done", 48'(done_w[SPARSE]), 48'd0);
      check("flushdone_c0_valid", 48'(valid_w[SPARSE]), 48'd0);
      repeat (4) step();
      check("flushdone_c4_valid", 48'(valid_w[SPARSE]), 48'd0);
      step();
      check("flushdone_c5_valid", 48'(valid_w[SPARSE]), 48'd1);

      // Single-iteration config: one issue at cycle 3, then done held.
      do_reset(SINGLE);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("single_c%0d_valid", k), 48'(valid_w[SINGLE]), 48'd0);
         step();
      end
      check("single_c3_valid", 48'(valid_w[SINGLE]), 48'd1);
      check("single_c3_vars", act_tup(SINGLE), tup(0, 0, 0));
      check("single_c3_done", 48'(done_w[SINGLE]), 48'd0);
      step();
      check("single_c4_done", 48'(done_w[SINGLE]), 48'd1);
      err = 0;
      for (int k = 0; k < 22; k++) begin
         if (valid_w[SINGLE] !== 1'b0 || done_w[SINGLE] !== 1'b1) err++;
         step();
      end
      check("single_idle_errors", 48'(err), 48'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
